// File: rtl/clause_loader.sv
// Clause loader: walks clause memory from index 0, latches each coefficient line and
// presents it to the clause register with a write strobe, honouring downstream hold.
module clause_loader #(
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 4,
  parameter int NUMBER_OF_INTEGER_VARIABLES   = 3,
  parameter int NUMBER_OF_CLAUSES             = 4,
  parameter int CLAUSE_INDEX_WIDTH            = 2
) (
  input  logic                                                           in_clk,
  input  logic                                                           in_reset_n,
  input  logic                                                           in_start,
  input  logic                                                           in_hold,
  output logic [CLAUSE_INDEX_WIDTH-1:0]                                  out_mem_address,
  output logic                                                           out_mem_read_enable,
  input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0] in_mem_data,
  output logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0] out_clause_coefficients,
  output logic                                                           out_write_enable,
  output logic [CLAUSE_INDEX_WIDTH-1:0]                                  out_clause_index,
  output logic                                                           out_busy,
  output logic                                                           out_done
);

  localparam int LINE_W = BIT_WIDTH_OF_INTEGER_VARIABLE * NUMBER_OF_INTEGER_VARIABLES;
  localparam logic [CLAUSE_INDEX_WIDTH-1:0] LAST_INDEX =
    CLAUSE_INDEX_WIDTH'(NUMBER_OF_CLAUSES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]                    state_q, state_d;
  logic [CLAUSE_INDEX_WIDTH-1:0] index_q, index_d;
  logic [LINE_W-1:0]             coef_q,  coef_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    coef_d  = coef_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          index_d = '0;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: begin
        coef_d  = in_mem_data;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // Index advances only once the consumer has taken the current line.
        if (!in_hold) begin
          if (index_q == LAST_INDEX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      coef_q  <= coef_d;
    end
  end

  assign out_mem_address         = index_q;
  assign out_mem_read_enable     = (state_q == ST_READ);
  assign out_clause_coefficients = coef_q;
  assign out_write_enable        = (state_q == ST_EMIT) && !in_hold;
  assign out_clause_index        = index_q;
  assign out_busy                = (state_q != ST_IDLE);
  assign out_done                = (state_q == ST_DONE);

endmodule
